// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 multiplexer.
//   state_t  : operating state, tracks the registered value of the mode input
//   ch_valid : true when a select value addresses an existing channel
package mux_pkg;

    typedef enum logic {
        S_DIRECT = 1'b0,
        S_SCAN   = 1'b1
    } state_t;

    // Only needed for non-power-of-2 channel counts, where the select
    // field can encode channels that do not exist.
    function automatic logic ch_valid(input int sel, input int ch);
        return (sel < ch);
    endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// Wrapping channel pointer for auto-scan mode, counting 0..CH-1.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active-low (pointer returns to 0)
//   clr   : restart the count at 0 this cycle
//   inc   : advance by one, wrapping CH-1 -> 0
//   ptr   : current pointer value
// clr and inc together give 1: the cleared value 0 is consumed by the
// same-cycle transfer and the count moves past it.
module mux_scan_ptr #(
    parameter int CH    = 4,
    parameter int SEL_W = $clog2(CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [SEL_W-1:0] ptr
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(CH - 1);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] base;

    always_comb begin
        base  = clr ? '0 : ptr_q;
        ptr_d = base;
        if (inc) begin
            ptr_d = (base == LAST) ? '0 : base + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/mux_nx1_reg.sv
// Parametrised CH-channel, WIDTH-bit registered multiplexer with a
// valid/ready output stage. Direct mode selects channel s; auto-scan mode
// walks an internal pointer through channels 0..CH-1, one per transfer.
// Ports:
//   clk, rst_n : clock (rising edge), synchronous active-low reset
//   en         : block enable; low holds state (output may still drain)
//   mode       : 0 = direct select, 1 = auto-scan
//   s          : channel select, direct mode only
//   d          : packed channel data, channel k = d[k*WIDTH +: WIDTH]
//   in_valid   : upstream sample offered
//   in_ready   : block can accept a sample this cycle
//   y, y_ch    : registered selected data and the channel it came from
//   out_valid  : y/y_ch hold an unconsumed sample
//   out_ready  : downstream consumes y this cycle
//   sel_err    : one-cycle pulse after a direct transfer with s >= CH
module mux_nx1_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CH    = 4,
    parameter int SEL_W = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    s,
    input  logic [CH*WIDTH-1:0] d,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIDTH-1:0]    y,
    output logic [SEL_W-1:0]    y_ch,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sel_err
);

    // Data padded to a power-of-2 channel count so an out-of-range select
    // reads zeros instead of running off the end of the vector.
    localparam int CH_P2 = 1 << SEL_W;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [SEL_W-1:0]   y_ch_q, y_ch_d;
    logic               out_valid_q, out_valid_d;
    logic               sel_err_q, sel_err_d;

    logic [CH_P2*WIDTH-1:0] d_pad;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   ptr_use;
    logic [SEL_W-1:0]   sel_idx;
    state_t             eff_state;
    logic               switch_ok;
    logic               ptr_clr;
    logic               ptr_inc;
    logic               xfer;
    logic               sel_ok;
    logic               load;

    mux_scan_ptr #(
        .CH    (CH),
        .SEL_W (SEL_W)
    ) u_scan_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ptr_clr),
        .inc   (ptr_inc),
        .ptr   (ptr)
    );

    always_comb begin
        d_pad                = '0;
        d_pad[CH*WIDTH-1:0]  = d;

        in_ready  = en & (~out_valid_q | out_ready);
        xfer      = in_valid & in_ready;

        // The mode may only change when the output stage is empty or
        // draining, which is exactly when the block could accept a sample.
        // A transfer in that same cycle already runs in the new state.
        switch_ok = in_ready;
        eff_state = switch_ok ? state_t'(mode) : state_q;
        state_d   = eff_state;

        // Entering scan restarts the pointer; a same-cycle transfer uses 0.
        ptr_clr   = switch_ok & mode & (state_q == S_DIRECT);
        ptr_use   = ptr_clr ? '0 : ptr;

        sel_idx   = (eff_state == S_SCAN) ? ptr_use : s;
        sel_ok    = (eff_state == S_SCAN) | ch_valid(int'(s), CH);
        load      = xfer & sel_ok;
        ptr_inc   = xfer & (eff_state == S_SCAN);

        y_d         = load ? d_pad[int'(sel_idx) * WIDTH +: WIDTH] : y_q;
        y_ch_d      = load ? sel_idx : y_ch_q;
        out_valid_d = load | (out_valid_q & ~out_ready);
        sel_err_d   = xfer & ~sel_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_DIRECT;
            y_q         <= '0;
            y_ch_q      <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            y_ch_q      <= y_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign y         = y_q;
    assign y_ch      = y_ch_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench for mux_nx1_reg: a table of directed vectors against
// a CH=4, WIDTH=8 instance, plus a hand-written select-error sequence
// against a CH=3 instance.
module tb_mux_nx1_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // CH=4, WIDTH=8 instance
    logic        rst_n, en, mode, in_valid, out_ready;
    logic [1:0]  s;
    logic [31:0] d;
    logic        in_ready, out_valid, sel_err;
    logic [7:0]  y;
    logic [1:0]  y_ch;

    mux_nx1_reg #(.WIDTH(8), .CH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .s         (s),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .y_ch      (y_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    // CH=3, WIDTH=8 instance
    logic        rst3_n, en3, mode3, iv3, or3;
    logic [1:0]  s3;
    logic [23:0] d3;
    logic        ir3, ov3, err3;
    logic [7:0]  y3;
    logic [1:0]  ych3;

    mux_nx1_reg #(.WIDTH(8), .CH(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst3_n),
        .en        (en3),
        .mode      (mode3),
        .s         (s3),
        .d         (d3),
        .in_valid  (iv3),
        .in_ready  (ir3),
        .y         (y3),
        .y_ch      (ych3),
        .out_valid (ov3),
        .out_ready (or3),
        .sel_err   (err3)
    );

    typedef struct {
        logic        rst_n, en, mode;
        logic [1:0]  s;
        logic [31:0] d;
        logic        iv, ordy;
        logic        chk_ir, exp_ir;
        logic [7:0]  exp_y;
        logic [1:0]  exp_ych;
        logic        exp_ov, exp_err;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Channel data {d3,d2,d1,d0}
    localparam logic [31:0] DA = 32'h44_A5_22_11;
    localparam logic [31:0] DB = 32'hDD_CC_BB_AA;

    task automatic add(input logic r, e, m, input logic [1:0] sv, input logic [31:0] dv,
                       input logic iv, ordy, ci, ei, input logic [7:0] ey,
                       input logic [1:0] ech, input logic eov, eerr);
        vq.push_back('{r, e, m, sv, dv, iv, ordy, ci, ei, ey, ech, eov, eerr});
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step3();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        rst3_n = 1'b0; en3 = 1'b1; mode3 = 1'b0; s3 = 2'd0;
        d3 = 24'h33_22_11; iv3 = 1'b0; or3 = 1'b0;

        //   rst en md s  d   iv or ci ei  y     ych ov er
        // Reset held two cycles with a sample offered
        add(0, 1, 0, 2, DA, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 0, 2, DA, 1, 0, 1, 1, 8'h00, 0, 0, 0);
        // First direct transfer, then stall, swap, drain
        add(1, 1, 0, 2, DA, 1, 0, 1, 1, 8'hA5, 2, 1, 0);
        add(1, 1, 0, 1, DA, 1, 0, 1, 0, 8'hA5, 2, 1, 0);
        add(1, 1, 0, 1, DA, 1, 1, 1, 1, 8'h22, 1, 1, 0);
        add(1, 1, 0, 1, DA, 0, 1, 1, 1, 8'h22, 1, 0, 0);
        // Scan wrap: channels 0,1,2,3,0,1 (s ignored)
        add(1, 1, 1, 3, DB, 1, 1, 1, 1, 8'hAA, 0, 1, 0);
        add(1, 1, 1, 3, DB, 1, 1, 1, 1, 8'hBB, 1, 1, 0);
        add(1, 1, 1, 3, DB, 1, 1, 1, 1, 8'hCC, 2, 1, 0);
        add(1, 1, 1, 3, DB, 1, 1, 1, 1, 8'hDD, 3, 1, 0);
        add(1, 1, 1, 3, DB, 1, 1, 1, 1, 8'hAA, 0, 1, 0);
        add(1, 1, 1, 3, DB, 1, 1, 1, 1, 8'hBB, 1, 1, 0);
        // Backpressure for 5 cycles, then resume at the next pointer
        for (int k = 0; k < 5; k++)
            add(1, 1, 1, 3, DB, 1, 0, 1, 0, 8'hBB, 1, 1, 0);
        add(1, 1, 1, 3, DB, 1, 1, 1, 1, 8'hCC, 2, 1, 0);
        // Back to direct, then request scan while stalled
        add(1, 1, 0, 0, DB, 1, 1, 1, 1, 8'hAA, 0, 1, 0);
        add(1, 1, 1, 0, DB, 1, 0, 1, 0, 8'hAA, 0, 1, 0);
        add(1, 1, 1, 0, DB, 1, 0, 1, 0, 8'hAA, 0, 1, 0);
        add(1, 1, 1, 0, DB, 0, 1, 1, 1, 8'hAA, 0, 0, 0);
        // Scan restarts at channel 0, not the stale pointer 3
        add(1, 1, 1, 0, DA, 1, 1, 1, 1, 8'h11, 0, 1, 0);
        add(1, 1, 1, 0, DA, 1, 1, 1, 1, 8'h22, 1, 1, 0);
        // en=0 with pointer at 2: drain only, no capture, no mode change
        add(1, 0, 1, 0, DA, 1, 1, 1, 0, 8'h22, 1, 0, 0);
        add(1, 0, 0, 0, DA, 1, 1, 1, 0, 8'h22, 1, 0, 0);
        add(1, 0, 0, 0, DA, 1, 1, 1, 0, 8'h22, 1, 0, 0);
        add(1, 1, 1, 0, DA, 1, 1, 1, 1, 8'hA5, 2, 1, 0);
        // Reset mid-scan: next scan transfer starts from channel 0
        add(0, 1, 1, 0, DA, 1, 1, 1, 1, 8'h00, 0, 0, 0);
        add(1, 1, 1, 0, DA, 1, 1, 1, 1, 8'h11, 0, 1, 0);
        // Direct select of the top channel, then drain
        add(1, 1, 0, 3, DB, 1, 1, 1, 1, 8'hDD, 3, 1, 0);
        add(1, 1, 0, 0, DB, 0, 1, 1, 1, 8'hDD, 3, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            v         = vq[i];
            rst_n     = v.rst_n;
            en        = v.en;
            mode      = v.mode;
            s         = v.s;
            d         = v.d;
            in_valid  = v.iv;
            out_ready = v.ordy;
            #1;
            if (v.chk_ir) chk("in_ready", i, 32'(in_ready), 32'(v.exp_ir));
            @(posedge clk);
            #1;
            chk("y",         i, 32'(y),         32'(v.exp_y));
            chk("y_ch",      i, 32'(y_ch),      32'(v.exp_ych));
            chk("out_valid", i, 32'(out_valid), 32'(v.exp_ov));
            chk("sel_err",   i, 32'(sel_err),   32'(v.exp_err));
        end

        // CH=3: select of the nonexistent channel 3
        iv3 = 1'b1;
        step3();
        step3();
        chk("c3_rst_y",  0, 32'(y3),  32'h00);
        chk("c3_rst_ov", 0, 32'(ov3), 32'h0);

        rst3_n = 1'b1; s3 = 2'd1; iv3 = 1'b1; or3 = 1'b0;
        step3();
        chk("c3_y",    1, 32'(y3),   32'h22);
        chk("c3_ych",  1, 32'(ych3), 32'h1);
        chk("c3_ov",   1, 32'(ov3),  32'h1);

        iv3 = 1'b0; or3 = 1'b1;
        step3();
        chk("c3_ov",   2, 32'(ov3),  32'h0);

        s3 = 2'd3; iv3 = 1'b1; or3 = 1'b0;
        #1;
        chk("c3_ir",   3, 32'(ir3),  32'h1);
        step3();
        chk("c3_err",  3, 32'(err3), 32'h1);
        chk("c3_y",    3, 32'(y3),   32'h22);
        chk("c3_ych",  3, 32'(ych3), 32'h1);
        chk("c3_ov",   3, 32'(ov3),  32'h0);

        iv3 = 1'b0;
        step3();
        chk("c3_err",  4, 32'(err3), 32'h0);

        en3 = 1'b0; s3 = 2'd3; iv3 = 1'b1;
        step3();
        chk("c3_err",  5, 32'(err3), 32'h0);
        chk("c3_ov",   5, 32'(ov3),  32'h0);

        en3 = 1'b1; s3 = 2'd2; iv3 = 1'b1; or3 = 1'b1;
        step3();
        chk("c3_y",    6, 32'(y3),   32'h33);
        chk("c3_ych",  6, 32'(ych3), 32'h2);
        chk("c3_ov",   6, 32'(ov3),  32'h1);
        chk("c3_err",  6, 32'(err3), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
